// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared state encoding, defaults and counter type for matvec_sequencer
package processor_pkg;

    localparam int MAX_N_C = 8;
    localparam int LANES_C = 4;
    localparam int CNT_W_C = $clog2(MAX_N_C + 1);

    typedef logic [CNT_W_C-1:0] seq_cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LOAD,
        OP,
        STORE,
        TX_POP,
        TX,
        DONE
    } seq_state_e;

endpackage

// File: rtl/lane_mask_gen.sv
// rtl/lane_mask_gen.sv - active lane count and enable mask for the current row group
module lane_mask_gen
    import processor_pkg::*;
#(
    parameter int CNT_W = $clog2(MAX_N_C + 1),
    parameter int LANES = LANES_C,
    parameter int AW    = $clog2(LANES + 1)
) (
    input  logic [CNT_W:0]   i_row_base,
    input  logic [CNT_W-1:0] i_n,
    output logic [LANES-1:0] o_mask,
    output logic [AW-1:0]    o_active
);

    localparam logic [CNT_W:0] LANES_W = (CNT_W + 1)'(LANES);

    logic [CNT_W:0] w_n_ext;
    logic [CNT_W:0] w_rem;

    assign w_n_ext = {1'b0, i_n};

    // rows still to process from row_base; zero once the base has passed N
    always_comb begin
        w_rem = '0;
        if (i_row_base < w_n_ext) begin
            w_rem = w_n_ext - i_row_base;
        end
    end

    // active = min(LANES, remaining rows)
    always_comb begin
        o_active = AW'(w_rem);
        if (w_rem >= LANES_W) begin
            o_active = AW'(LANES);
        end
    end

    // thermometer mask: lanes below the active count are enabled
    always_comb begin
        o_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            o_mask[i] = (AW'(i) < o_active);
        end
    end

endmodule

// File: rtl/matvec_sequencer.sv
// rtl/matvec_sequencer.sv - grouped N x N matrix-vector sequencer; define ABORT_EN to add abort/aborted
module matvec_sequencer
    import processor_pkg::*;
#(
    parameter int MAX_N = MAX_N_C,
    parameter int LANES = LANES_C,
    parameter int CNT_W = $clog2(MAX_N + 1),
    parameter int SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_size,
    input  logic             in_empty,
    input  logic             res_full,
    input  logic             tx_ready,
`ifdef ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             busy,
    output logic             done,
    output logic             err_size,
    output logic             pop,
    output logic [LANES-1:0] lane_en,
    output logic             lane_retro,
    output logic             push_res,
    output logic [SEL_W-1:0] res_sel,
    output logic             pop_res,
    output logic             transmit,
    output logic [CNT_W-1:0] row_base
);

    localparam int               AW      = $clog2(LANES + 1);
    localparam logic [CNT_W:0]   LANES_W = (CNT_W + 1)'(LANES);
    localparam logic [CNT_W-1:0] MAX_N_W = CNT_W'(MAX_N);
    localparam logic [CNT_W-1:0] ONE_N   = CNT_W'(1);
    localparam logic [AW-1:0]    ONE_A   = AW'(1);

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_col_cnt;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [AW-1:0]    r_lane_cnt;
    logic [CNT_W:0]   r_row_base;

    logic [LANES-1:0] w_mask;
    logic [AW-1:0]    w_active;
    logic [CNT_W:0]   w_row_next;
    logic             w_latch;
    logic             w_clear;
    logic             w_col_inc;
    logic             w_col_clr;
    logic             w_lane_inc;
    logic             w_group_end;
    logic             w_tx_inc;
    logic             w_tx_clr;
    logic             w_abort;

`ifdef ABORT_EN
    assign w_abort = abort && (r_state != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // row_base is one bit wider than N so this sum never wraps
    assign w_row_next = r_row_base + LANES_W;
    assign row_base   = r_row_base[CNT_W-1:0];

    lane_mask_gen #(
        .CNT_W (CNT_W),
        .LANES (LANES),
        .AW    (AW)
    ) u_lane_mask_gen (
        .i_row_base (r_row_base),
        .i_n        (r_n),
        .o_mask     (w_mask),
        .o_active   (w_active)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state decode, output strobes and counter control
    always_comb begin
        w_next      = r_state;
        busy        = (r_state != IDLE);
        done        = 1'b0;
        err_size    = 1'b0;
        pop         = 1'b0;
        lane_en     = '0;
        lane_retro  = 1'b0;
        push_res    = 1'b0;
        res_sel     = '0;
        pop_res     = 1'b0;
        transmit    = 1'b0;
        w_latch     = 1'b0;
        w_clear     = 1'b0;
        w_col_inc   = 1'b0;
        w_col_clr   = 1'b0;
        w_lane_inc  = 1'b0;
        w_group_end = 1'b0;
        w_tx_inc    = 1'b0;
        w_tx_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_latch = 1'b1;
                    w_next  = CHECK;
                end
            end
            CHECK: begin
                if ((r_n == '0) || (r_n > MAX_N_W)) begin
                    err_size = 1'b1;
                    w_next   = IDLE;
                end else begin
                    w_clear = 1'b1;
                    w_next  = LOAD;
                end
            end
            LOAD: begin
                pop = !in_empty;
                if (!in_empty) begin
                    w_next = OP;
                end
            end
            OP: begin
                lane_en    = w_mask;
                lane_retro = (r_col_cnt != '0);
                if (r_col_cnt == r_n - ONE_N) begin
                    w_col_clr = 1'b1;
                    w_next    = STORE;
                end else begin
                    w_col_inc = 1'b1;
                    w_next    = LOAD;
                end
            end
            STORE: begin
                res_sel  = r_lane_cnt[SEL_W-1:0];
                push_res = !res_full;
                if (!res_full) begin
                    if (r_lane_cnt == w_active - ONE_A) begin
                        w_group_end = 1'b1;
                        w_next      = (w_row_next >= {1'b0, r_n}) ? TX_POP : LOAD;
                    end else begin
                        w_lane_inc = 1'b1;
                    end
                end
            end
            TX_POP: begin
                pop_res = 1'b1;
                w_next  = TX;
            end
            TX: begin
                transmit = 1'b1;
                if (tx_ready) begin
                    if (r_tx_cnt == r_n - ONE_N) begin
                        w_tx_clr = 1'b1;
                        w_next   = DONE;
                    end else begin
                        w_tx_inc = 1'b1;
                        w_next   = TX_POP;
                    end
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (w_abort) begin
            w_next  = IDLE;
            w_clear = 1'b1;
            done    = 1'b0;
        end
    end

    // size latch and column/lane/word/row-group counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n        <= '0;
            r_col_cnt  <= '0;
            r_lane_cnt <= '0;
            r_tx_cnt   <= '0;
            r_row_base <= '0;
        end else begin
            if (w_latch) begin
                r_n <= n_size;
            end
            if (w_clear) begin
                r_col_cnt  <= '0;
                r_lane_cnt <= '0;
                r_tx_cnt   <= '0;
                r_row_base <= '0;
            end else begin
                if (w_col_clr) begin
                    r_col_cnt <= '0;
                end else if (w_col_inc) begin
                    r_col_cnt <= r_col_cnt + ONE_N;
                end
                if (w_group_end) begin
                    r_lane_cnt <= '0;
                    r_row_base <= w_row_next;
                end else if (w_lane_inc) begin
                    r_lane_cnt <= r_lane_cnt + ONE_A;
                end
                if (w_tx_clr) begin
                    r_tx_cnt <= '0;
                end else if (w_tx_inc) begin
                    r_tx_cnt <= r_tx_cnt + ONE_N;
                end
            end
        end
    end

`ifdef ABORT_EN
    // one-cycle pulse following an accepted abort
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aborted <= 1'b0;
        end else begin
            aborted <= w_abort;
        end
    end
`endif

endmodule
